// File: rtl/dm_mult_periph.sv
// dm_mult_periph: memory-mapped iterative 32x32 multiplier on the CPU data-memory bus.
//
// Software writes OPA and OPB, writes START (CTRL bit0), polls STATUS, then reads
// the 64-bit product from RES_LO/RES_HI. One multiplier bit is processed per
// cycle, so a product is ready 33 edges after the START edge.
//
// Register window (byte offsets from BASE_ADDR, word aligned):
//   0x00 OPA     RW  operand A
//   0x04 OPB     RW  operand B
//   0x08 CTRL    W   bit0 = START
//        STATUS  R   {30'b0, done, busy}
//   0x0C RES_LO  R   product bits 31:0
//   0x10 RES_HI  R   product bits 63:32
//
// Ports:
//   clk         clock, all state updates on rising edge
//   rst         synchronous reset, active-high
//   dm_address  CPU data-memory byte address
//   dm_d        CPU write data
//   dm_we       CPU write enable
//   sel         address hits this register window (combinational)
//   rd_data     combinational read data, 0 when sel=0
//   busy        multiply in progress (mirror of STATUS[0])
//   irq_done    one-cycle pulse on completion
//
// FSM states:
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for a START write; operands latched on START
//   ST_BUSY | shift-add step for multiplicand bit cnt (0..31)
//   ST_FIX  | apply product sign, publish result, pulse irq_done

module dm_mult_periph #(
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter bit          SIGNED    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dm_address,
    input  logic [31:0] dm_d,
    input  logic        dm_we,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        irq_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        sign_q;
    logic [63:0] acc;
    logic [63:0] res;
    logic [4:0]  cnt;
    logic        done;

    logic [15:0] offset;
    logic [2:0]  word_off;
    logic        wr_opa;
    logic        wr_opb;
    logic        wr_start;

    // Range check on the unsigned difference avoids overflow when the window
    // sits near the top of the address space.
    assign offset   = dm_address - BASE_ADDR;
    assign sel      = (dm_address >= BASE_ADDR) && (offset <= 16'd16) && (offset[1:0] == 2'b00);
    assign word_off = offset[4:2];

    assign wr_opa   = sel && dm_we && (word_off == 3'd0);
    assign wr_opb   = sel && dm_we && (word_off == 3'd1);
    assign wr_start = sel && dm_we && (word_off == 3'd2) && dm_d[0];

    always_comb begin
        rd_data = 32'd0;
        if (sel) begin
            case (word_off)
                3'd0:    rd_data = opa;
                3'd1:    rd_data = opb;
                3'd2:    rd_data = {30'd0, done, busy};
                3'd3:    rd_data = res[31:0];
                3'd4:    rd_data = res[63:32];
                default: rd_data = 32'd0;
            endcase
        end
    end

    // Magnitude of an operand; 0x80000000 maps to 2^31, which still fits in 32 bits.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        if (SIGNED && v[31])
            return 32'd0 - v;
        else
            return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            opa      <= 32'd0;
            opb      <= 32'd0;
            mcand    <= 32'd0;
            mplier   <= 32'd0;
            sign_q   <= 1'b0;
            acc      <= 64'd0;
            res      <= 64'd0;
            cnt      <= 5'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            irq_done <= 1'b0;
        end else begin
            irq_done <= 1'b0;

            // Operand registers stay writable while busy; the running
            // operation works from its own latched copies.
            if (wr_opa)
                opa <= dm_d;
            if (wr_opb)
                opb <= dm_d;

            case (state)
                ST_IDLE: begin
                    if (wr_start) begin
                        mcand  <= magnitude(opa);
                        mplier <= magnitude(opb);
                        sign_q <= SIGNED ? (opa[31] ^ opb[31]) : 1'b0;
                        acc    <= 64'd0;
                        cnt    <= 5'd0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        state  <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (mcand[cnt])
                        acc <= acc + ({32'd0, mplier} << cnt);
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= ST_FIX;
                end

                ST_FIX: begin
                    res      <= sign_q ? (64'd0 - acc) : acc;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    irq_done <= 1'b1;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_mult_periph.sv
// Testbench for dm_mult_periph: one signed and one unsigned instance share the
// CPU bus. Expected products come from a behavioural multiply and are queued
// when START is written, then popped when the operation completes.
module tb_dm_mult_periph;

    localparam logic [15:0] BASE = 16'h0800;

    logic        clk;
    logic        rst;
    logic [15:0] dm_address;
    logic [31:0] dm_d;
    logic        dm_we;

    logic        sel_v  [2];
    logic [31:0] rd     [2];
    logic        busy_v [2];
    logic        irq_v  [2];

    dm_mult_periph #(.BASE_ADDR(BASE), .SIGNED(1'b1)) u_dut_s (
        .clk        (clk),
        .rst        (rst),
        .dm_address (dm_address),
        .dm_d       (dm_d),
        .dm_we      (dm_we),
        .sel        (sel_v[0]),
        .rd_data    (rd[0]),
        .busy       (busy_v[0]),
        .irq_done   (irq_v[0])
    );

    dm_mult_periph #(.BASE_ADDR(BASE), .SIGNED(1'b0)) u_dut_u (
        .clk        (clk),
        .rst        (rst),
        .dm_address (dm_address),
        .dm_d       (dm_d),
        .dm_we      (dm_we),
        .sel        (sel_v[1]),
        .rd_data    (rd[1]),
        .busy       (busy_v[1]),
        .irq_done   (irq_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] s;
        logic [63:0] u;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_res [2];
    logic [31:0] exp_opa;
    logic [31:0] exp_opb;
    int          done_at   [2];
    int          irq_cnt   [2];
    int          busy_last [2];

    function automatic logic [63:0] model_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    function automatic logic [63:0] model_u(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // All bus tasks are entered just after a falling edge.
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        dm_address = a;
        dm_d       = d;
        dm_we      = 1'b1;
        @(negedge clk);
        dm_we      = 1'b0;
    endtask

    task automatic set_addr(input logic [15:0] a);
        dm_address = a;
        dm_we      = 1'b0;
        #1;
    endtask

    // Counts falling edges from start_n+1 (edges elapsed since the START edge),
    // recording first done, irq pulses and last cycle busy was high.
    task automatic wait_done(input int start_n);
        for (int i = 0; i < 2; i++) begin
            done_at[i]   = -1;
            irq_cnt[i]   = 0;
            busy_last[i] = -1;
        end
        dm_address = BASE + 16'h8;
        for (int n = start_n + 1; n <= 45; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rd[i][1] === 1'b1 && done_at[i] < 0) done_at[i] = n;
                if (irq_v[i] === 1'b1) irq_cnt[i]++;
                if (busy_v[i] === 1'b1) busy_last[i] = n;
            end
        end
    endtask

    task automatic check_timing();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (done_at[i] !== 33) begin
                $display("FAIL done_latency inst %0d got %0d want 33", i, done_at[i]);
                errors++;
            end
            checks++;
            if (irq_cnt[i] !== 1) begin
                $display("FAIL irq_width inst %0d got %0d want 1", i, irq_cnt[i]);
                errors++;
            end
            checks++;
            if (busy_last[i] !== 32) begin
                $display("FAIL busy_last inst %0d got %0d want 32", i, busy_last[i]);
                errors++;
            end
        end
    endtask

    task automatic check_result();
        exp_t        e;
        logic [63:0] want [2];
        checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty got 0 entries want 1");
            errors++;
        end else begin
            e       = sb_q.pop_front();
            want[0] = e.s;
            want[1] = e.u;
            for (int i = 0; i < 2; i++) begin
                set_addr(BASE + 16'hC);
                checks++;
                if (rd[i] !== want[i][31:0]) begin
                    $display("FAIL res_lo inst %0d got %h want %h", i, rd[i], want[i][31:0]);
                    errors++;
                end
                set_addr(BASE + 16'h10);
                checks++;
                if (rd[i] !== want[i][63:32]) begin
                    $display("FAIL res_hi inst %0d got %h want %h", i, rd[i], want[i][63:32]);
                    errors++;
                end
                last_res[i] = want[i];
            end
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        bus_write(BASE, a);
        bus_write(BASE + 16'h4, b);
        exp_opa = a;
        exp_opb = b;
        e.s = model_s(a, b);
        e.u = model_u(a, b);
        if (push) sb_q.push_back(e);
        bus_write(BASE + 16'h8, 32'h1);
        set_addr(BASE + 16'h8);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rd[i] !== 32'h1 || busy_v[i] !== 1'b1) begin
                $display("FAIL start_status inst %0d got %h busy %b want 00000001 busy 1",
                         i, rd[i], busy_v[i]);
                errors++;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        start_op(a, b, 1'b1);
        wait_done(0);
        check_timing();
        check_result();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        dm_we      = 1'b0;
        dm_d       = 32'd0;
        dm_address = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_addr(BASE + 16'(4 * k));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rd[i] !== 32'd0) begin
                    $display("FAIL reset_reg%0d inst %0d got %h want 0", k, i, rd[i]);
                    errors++;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy_v[i] !== 1'b0 || irq_v[i] !== 1'b0) begin
                $display("FAIL reset_outputs inst %0d got busy %b irq %b want 0 0",
                         i, busy_v[i], irq_v[i]);
                errors++;
            end
            last_res[i] = 64'd0;
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(32'd9, 32'hFFFF_FFF5);
        run_op(32'h8000_0000, 32'h8000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++)
            run_op($urandom, $urandom);
    endtask

    task automatic test_back_to_back();
        logic [63:0] prev [2];
        prev[0] = last_res[0];
        prev[1] = last_res[1];
        start_op(32'd9, 32'hFFFF_FFF5, 1'b1);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 5) begin
                set_addr(BASE + 16'hC);
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (rd[i] !== prev[i][31:0]) begin
                        $display("FAIL res_hold inst %0d got %h want %h", i, rd[i], prev[i][31:0]);
                        errors++;
                    end
                end
            end
        end
        bus_write(BASE, 32'd3);
        bus_write(BASE + 16'h8, 32'h1);
        checks++;
        if (sb_q.size() != 1) begin
            $display("FAIL sb_depth got %0d want 1", sb_q.size());
            errors++;
        end
        wait_done(11);
        check_timing();
        check_result();
        set_addr(BASE);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rd[i] !== 32'd3) begin
                $display("FAIL opa_update inst %0d got %h want 00000003", i, rd[i]);
                errors++;
            end
        end
        run_op(32'd3, 32'hFFFF_FFF5);
    endtask

    task automatic test_abort();
        start_op(32'd5, 32'd7, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_addr(BASE + 16'h8);
            checks++;
            if (rd[i] !== 32'd0 || busy_v[i] !== 1'b0) begin
                $display("FAIL abort_status inst %0d got %h busy %b want 0", i, rd[i], busy_v[i]);
                errors++;
            end
            set_addr(BASE + 16'hC);
            checks++;
            if (rd[i] !== 32'd0) begin
                $display("FAIL abort_res_lo inst %0d got %h want 0", i, rd[i]);
                errors++;
            end
            set_addr(BASE + 16'h10);
            checks++;
            if (rd[i] !== 32'd0) begin
                $display("FAIL abort_res_hi inst %0d got %h want 0", i, rd[i]);
                errors++;
            end
            last_res[i] = 64'd0;
        end
        wait_done(0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (irq_cnt[i] !== 0 || done_at[i] !== -1 || busy_last[i] !== -1) begin
                $display("FAIL abort_quiet inst %0d got irq %0d done %0d busy %0d want 0 -1 -1",
                         i, irq_cnt[i], done_at[i], busy_last[i]);
                errors++;
            end
        end
        run_op(32'hFFFF_FFF9, 32'd6);
    endtask

    task automatic test_address();
        logic [15:0] bad [3];
        bad[0] = BASE - 16'h4;
        bad[1] = BASE + 16'h14;
        bad[2] = BASE + 16'h2;
        for (int k = 0; k < 3; k++) begin
            bus_write(bad[k], 32'hDEAD_BEEF);
            set_addr(bad[k]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (sel_v[i] !== 1'b0 || rd[i] !== 32'd0) begin
                    $display("FAIL outside_sel inst %0d addr %h got sel %b rd %h want 0 0",
                             i, bad[k], sel_v[i], rd[i]);
                    errors++;
                end
            end
        end
        set_addr(BASE + 16'h10);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sel_v[i] !== 1'b1) begin
                $display("FAIL top_sel inst %0d got %b want 1", i, sel_v[i]);
                errors++;
            end
        end
        bus_write(BASE + 16'h8, 32'hFFFF_FFFE);
        bus_write(BASE + 16'hC, 32'h1234_5678);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            set_addr(BASE);
            checks++;
            if (rd[i] !== exp_opa) begin
                $display("FAIL opa_kept inst %0d got %h want %h", i, rd[i], exp_opa);
                errors++;
            end
            set_addr(BASE + 16'h4);
            checks++;
            if (rd[i] !== exp_opb) begin
                $display("FAIL opb_kept inst %0d got %h want %h", i, rd[i], exp_opb);
                errors++;
            end
            set_addr(BASE + 16'h8);
            checks++;
            if (rd[i] !== 32'h2 || busy_v[i] !== 1'b0) begin
                $display("FAIL ctrl_zero inst %0d got %h busy %b want 00000002 0", i, rd[i], busy_v[i]);
                errors++;
            end
            set_addr(BASE + 16'hC);
            checks++;
            if (rd[i] !== last_res[i][31:0]) begin
                $display("FAIL res_ro inst %0d got %h want %h", i, rd[i], last_res[i][31:0]);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_abort();
        test_address();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
